// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX_RR, EX_I, EX_SH, BEQ, BNE, JMP, EX_CMP,
        ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_RR, CL_I, CL_SH, CL_BEQ, CL_BNE, CL_JMP, CL_LOAD, CL_STORE, CL_CMP
    } iclass_t;

    localparam logic [3:0] c_OP_RR_A  = 4'b1000;
    localparam logic [3:0] c_OP_RR_B  = 4'b1100;
    localparam logic [3:0] c_OP_RR_C  = 4'b1011;
    localparam logic [3:0] c_OP_RR_D  = 4'b1111;
    localparam logic [3:0] c_OP_I_A   = 4'b0110;
    localparam logic [3:0] c_OP_I_B   = 4'b0111;
    localparam logic [3:0] c_OP_I_C   = 4'b1101;
    localparam logic [3:0] c_OP_I_D   = 4'b1001;
    localparam logic [3:0] c_OP_SH_A  = 4'b1110;
    localparam logic [3:0] c_OP_SH_B  = 4'b1010;
    localparam logic [3:0] c_OP_BEQ   = 4'b0100;
    localparam logic [3:0] c_OP_BNE   = 4'b0101;
    localparam logic [3:0] c_OP_JMP   = 4'b0011;
    localparam logic [3:0] c_OP_LOAD  = 4'b0001;
    localparam logic [3:0] c_OP_STORE = 4'b0010;
    localparam logic [3:0] c_OP_CMP   = 4'b0000;

    localparam logic [2:0] c_ALUOP_ADD = 3'b000;
    localparam logic [2:0] c_ALUOP_ALU = 3'b001;
    localparam logic [2:0] c_ALUOP_CMP = 3'b010;
    localparam logic [2:0] c_ALUOP_SUB = 3'b011;

    localparam logic [2:0] c_SRCB_REGB   = 3'b000;
    localparam logic [2:0] c_SRCB_JOFF   = 3'b001;
    localparam logic [2:0] c_SRCB_IMM    = 3'b010;
    localparam logic [2:0] c_SRCB_ONE    = 3'b011;
    localparam logic [2:0] c_SRCB_SHAMT  = 3'b100;
    localparam logic [2:0] c_SRCB_MEMOFF = 3'b101;

    localparam logic [1:0] c_TRAP_NONE    = 2'b00;
    localparam logic [1:0] c_TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] c_TRAP_IM_TMO  = 2'b10;
    localparam logic [1:0] c_TRAP_DM_TMO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_controller_hs_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_op_decode
// Purpose  : Combinational opcode classifier with illegal-opcode detection.
// Revision : 1.0 - initial release
// ============================================================================
module mc_op_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output iclass_t        iclass,
    output logic           illegal
);

    generate
        if (OPW > 4) begin : g_wide
            assign illegal = |op[OPW-1:4];
        end else begin : g_narrow
            assign illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        iclass = CL_CMP;
        case (op[3:0])
            c_OP_RR_A, c_OP_RR_B, c_OP_RR_C, c_OP_RR_D: iclass = CL_RR;
            c_OP_I_A, c_OP_I_B, c_OP_I_C, c_OP_I_D:     iclass = CL_I;
            c_OP_SH_A, c_OP_SH_B:                       iclass = CL_SH;
            c_OP_BEQ:                                   iclass = CL_BEQ;
            c_OP_BNE:                                   iclass = CL_BNE;
            c_OP_JMP:                                   iclass = CL_JMP;
            c_OP_LOAD:                                  iclass = CL_LOAD;
            c_OP_STORE:                                 iclass = CL_STORE;
            default:                                    iclass = CL_CMP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller_hs.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller_hs
// Purpose  : Multi-cycle control FSM with memory handshakes, watchdog and trap.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller_hs
    import mc_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int ALUOPW      = 3,
    parameter int SRCBW       = 3,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNTW        = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [OPW-1:0]    Op,
    input  logic              ImReady,
    input  logic              DmReady,
    output logic              PCWrite,
    output logic              PCWriteCondEq,
    output logic              PCWriteCondNeq,
    output logic              PCSrc,
    output logic              IMRead,
    output logic              IMWrite,
    output logic              DMRead,
    output logic              DMWrite,
    output logic              IRWrite,
    output logic [1:0]        MemtoReg,
    output logic              ALUSrcA,
    output logic [SRCBW-1:0]  ALUSrcB,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              InstrDone,
    output logic              Trap,
    output logic [1:0]        TrapCause
);

    state_t          r_state;
    state_t          w_next;
    iclass_t         w_cls;
    logic            w_illegal;
    logic [CNTW-1:0] r_cnt;
    logic            w_wait;
    logic            w_limit;
    logic [1:0]      w_cause;
    logic            r_trap;
    logic [1:0]      r_cause;

    mc_op_decode #(.OPW(OPW)) u_dec (
        .op      (Op),
        .iclass  (w_cls),
        .illegal (w_illegal)
    );

    assign w_wait  = ((r_state == FETCH) && !ImReady) ||
                     (((r_state == MEM_RD) || (r_state == MEM_WR)) && !DmReady);
    // Limit fires on the MEM_TIMEOUT-th consecutive wait cycle; ready in that cycle still wins.
    assign w_limit = (MEM_TIMEOUT != 0) && (r_cnt == CNTW'(MEM_TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= FETCH;
            r_cnt   <= '0;
            r_trap  <= 1'b0;
            r_cause <= c_TRAP_NONE;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_wait)
                r_cnt <= r_cnt + CNTW'(1);
            if ((w_next == TRAP) && (r_state != TRAP)) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    assign Trap      = r_trap;
    assign TrapCause = r_cause;

    always_comb begin
        w_next         = r_state;
        w_cause        = c_TRAP_NONE;
        PCWrite        = 1'b0;
        PCWriteCondEq  = 1'b0;
        PCWriteCondNeq = 1'b0;
        PCSrc          = 1'b0;
        IMRead         = 1'b0;
        IMWrite        = 1'b0;
        DMRead         = 1'b0;
        DMWrite        = 1'b0;
        IRWrite        = 1'b0;
        MemtoReg       = 2'b00;
        ALUSrcA        = 1'b0;
        ALUSrcB        = '0;
        ALUOp          = '0;
        RegWrite       = 1'b0;
        RegDst         = 1'b0;
        InstrDone      = 1'b0;
        // Outputs stay at zero while Reset is held, even though the state is already FETCH.
        if (!Reset) begin
            case (r_state)
                FETCH: begin
                    IMRead  = 1'b1;
                    ALUSrcB = SRCBW'(c_SRCB_ONE);
                    ALUOp   = ALUOPW'(c_ALUOP_ADD);
                    if (ImReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = DECODE;
                    end else if (w_limit) begin
                        w_next  = TRAP;
                        w_cause = c_TRAP_IM_TMO;
                    end
                end
                DECODE: begin
                    if (w_illegal) begin
                        w_next  = TRAP;
                        w_cause = c_TRAP_ILLEGAL;
                    end else begin
                        case (w_cls)
                            CL_RR:             w_next = EX_RR;
                            CL_I:              w_next = EX_I;
                            CL_SH:             w_next = EX_SH;
                            CL_BEQ:            w_next = BEQ;
                            CL_BNE:            w_next = BNE;
                            CL_JMP:            w_next = JMP;
                            CL_LOAD, CL_STORE: w_next = ADDR;
                            default:           w_next = EX_CMP;
                        endcase
                    end
                end
                EX_RR, EX_I, EX_SH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOPW'(c_ALUOP_ALU);
                    ALUSrcB = (r_state == EX_RR) ? SRCBW'(c_SRCB_REGB) :
                              (r_state == EX_I)  ? SRCBW'(c_SRCB_IMM)  :
                                                   SRCBW'(c_SRCB_SHAMT);
                    w_next  = WB_ALU;
                end
                BEQ, BNE: begin
                    ALUSrcA        = 1'b1;
                    ALUSrcB        = SRCBW'(c_SRCB_REGB);
                    ALUOp          = ALUOPW'(c_ALUOP_SUB);
                    PCSrc          = 1'b1;
                    PCWriteCondEq  = (r_state == BEQ);
                    PCWriteCondNeq = (r_state == BNE);
                    InstrDone      = 1'b1;
                    w_next         = FETCH;
                end
                JMP: begin
                    ALUSrcB   = SRCBW'(c_SRCB_JOFF);
                    ALUOp     = ALUOPW'(c_ALUOP_ALU);
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = FETCH;
                end
                EX_CMP: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = SRCBW'(c_SRCB_REGB);
                    ALUOp     = ALUOPW'(c_ALUOP_CMP);
                    MemtoReg  = 2'b01;
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = FETCH;
                end
                ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCBW'(c_SRCB_MEMOFF);
                    ALUOp   = ALUOPW'(c_ALUOP_ADD);
                    w_next  = (w_cls == CL_LOAD) ? MEM_RD : MEM_WR;
                end
                MEM_RD, MEM_WR: begin
                    DMRead  = (r_state == MEM_RD);
                    DMWrite = (r_state == MEM_WR);
                    if (DmReady) begin
                        InstrDone = (r_state == MEM_WR);
                        w_next    = (r_state == MEM_RD) ? WB_MEM : FETCH;
                    end else if (w_limit) begin
                        w_next  = TRAP;
                        w_cause = c_TRAP_DM_TMO;
                    end
                end
                WB_ALU: begin
                    MemtoReg  = 2'b10;
                    RegWrite  = 1'b1;
                    RegDst    = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = FETCH;
                end
                WB_MEM: begin
                    MemtoReg  = 2'b00;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                    w_next    = FETCH;
                end
                default: w_next = r_state;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mc_controller_hs
// Purpose  : Randomized cycle-by-cycle check of mc_controller_hs against a script model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller_hs;

    localparam int OPW    = 5;
    localparam int ALUOPW = 3;
    localparam int SRCBW  = 3;
    localparam int TMO    = 5;
    localparam int CNTW   = 8;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [OPW-1:0]    Op = '0;
    logic              ImReady = 1'b0;
    logic              DmReady = 1'b0;
    logic              PCWrite, PCWriteCondEq, PCWriteCondNeq, PCSrc;
    logic              IMRead, IMWrite, DMRead, DMWrite, IRWrite;
    logic [1:0]        MemtoReg;
    logic              ALUSrcA;
    logic [SRCBW-1:0]  ALUSrcB;
    logic [ALUOPW-1:0] ALUOp;
    logic              RegWrite, RegDst, InstrDone, Trap;
    logic [1:0]        TrapCause;

    mc_controller_hs #(
        .OPW(OPW), .ALUOPW(ALUOPW), .SRCBW(SRCBW), .MEM_TIMEOUT(TMO), .CNTW(CNTW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .ImReady(ImReady), .DmReady(DmReady),
        .PCWrite(PCWrite), .PCWriteCondEq(PCWriteCondEq), .PCWriteCondNeq(PCWriteCondNeq),
        .PCSrc(PCSrc), .IMRead(IMRead), .IMWrite(IMWrite), .DMRead(DMRead),
        .DMWrite(DMWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst),
        .InstrDone(InstrDone), .Trap(Trap), .TrapCause(TrapCause)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       pcw, ceq, cne, pcsrc, imr, imw, dmr, dmw, irw;
        logic [1:0] m2r;
        logic       srca;
        logic [2:0] srcb;
        logic [2:0] aluop;
        logic       regw, regdst, done, trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct packed {
        logic  im;
        logic  dm;
        outs_t exp;
    } cyc_t;

    outs_t got;
    assign got = {PCWrite, PCWriteCondEq, PCWriteCondNeq, PCSrc, IMRead, IMWrite,
                  DMRead, DMWrite, IRWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                  RegWrite, RegDst, InstrDone, Trap, TrapCause};

    cyc_t  q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "";
    bit    trapped = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic im, input logic dm, input outs_t e);
        q.push_back({im, dm, e});
    endtask

    task automatic push_trap(input logic [1:0] cause);
        outs_t o;
        o = '0;
        o.trap  = 1'b1;
        o.cause = cause;
        repeat (3) push(rb(), rb(), o);
        trapped = 1'b1;
    endtask

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o;
        o = '0;
        o.imr  = 1'b1;
        o.srcb = 3'b011;
        o.irw  = rdy;
        o.pcw  = rdy;
        return o;
    endfunction

    // Expected per-cycle outputs of one instruction: wf/wd are the number of
    // not-ready cycles the instruction/data memories present before ready.
    task automatic gen_instr(input logic [OPW-1:0] op, input int wf, input int wd);
        outs_t      o;
        logic [3:0] lo;
        logic       is_ld;
        lo = op[3:0];
        if (wf >= TMO) begin
            repeat (TMO) push(1'b0, rb(), o_fetch(1'b0));
            push_trap(2'b10);
            return;
        end
        repeat (wf) push(1'b0, rb(), o_fetch(1'b0));
        push(1'b1, rb(), o_fetch(1'b1));
        push(rb(), rb(), '0);
        if (op[OPW-1:4] != '0) begin
            push_trap(2'b01);
            return;
        end
        o = '0;
        case (lo)
            4'b1000, 4'b1100, 4'b1011, 4'b1111,
            4'b0110, 4'b0111, 4'b1101, 4'b1001,
            4'b1110, 4'b1010: begin
                o.srca  = 1'b1;
                o.aluop = 3'b001;
                if (lo inside {4'b0110, 4'b0111, 4'b1101, 4'b1001}) o.srcb = 3'b010;
                else if (lo inside {4'b1110, 4'b1010})              o.srcb = 3'b100;
                else                                                o.srcb = 3'b000;
                push(rb(), rb(), o);
                o = '0;
                o.m2r = 2'b10; o.regw = 1'b1; o.regdst = 1'b1; o.done = 1'b1;
                push(rb(), rb(), o);
            end
            4'b0100, 4'b0101: begin
                o.srca = 1'b1; o.aluop = 3'b011; o.pcsrc = 1'b1; o.done = 1'b1;
                o.ceq  = (lo == 4'b0100);
                o.cne  = (lo == 4'b0101);
                push(rb(), rb(), o);
            end
            4'b0011: begin
                o.srcb = 3'b001; o.aluop = 3'b001; o.pcw = 1'b1; o.done = 1'b1;
                push(rb(), rb(), o);
            end
            4'b0000: begin
                o.srca = 1'b1; o.aluop = 3'b010; o.m2r = 2'b01;
                o.regw = 1'b1; o.regdst = 1'b1; o.done = 1'b1;
                push(rb(), rb(), o);
            end
            default: begin
                is_ld  = (lo == 4'b0001);
                o.srca = 1'b1;
                o.srcb = 3'b101;
                push(rb(), rb(), o);
                o = '0;
                o.dmr = is_ld;
                o.dmw = !is_ld;
                if (wd >= TMO) begin
                    repeat (TMO) push(rb(), 1'b0, o);
                    push_trap(2'b11);
                    return;
                end
                repeat (wd) push(rb(), 1'b0, o);
                o.done = !is_ld;
                push(rb(), 1'b1, o);
                if (is_ld) begin
                    o = '0;
                    o.regw = 1'b1; o.done = 1'b1;
                    push(rb(), rb(), o);
                end
            end
        endcase
    endtask

    // Play up to 'limit' queued cycles (all when negative) and discard the rest.
    task automatic run_q(input int limit);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            c = q.pop_front();
            ImReady = c.im;
            DmReady = c.dm;
            @(negedge Clk);
            check($sformatf("%s.c%0d", cur_tag, n), 32'(got), 32'(c.exp));
            @(posedge Clk);
            #1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check({cur_tag, ".rst"}, 32'(got), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset   = 1'b0;
        trapped = 1'b0;
    endtask

    task automatic one(input string tag, input logic [OPW-1:0] op, input int wf, input int wd);
        cur_tag = tag;
        Op      = op;
        gen_instr(op, wf, wd);
        run_q(-1);
        if (trapped) do_reset();
    endtask

    initial begin
        logic [OPW-1:0] op;
        int             wf, wd;
        @(posedge Clk);
        #1;
        check("init_rst", 32'(got), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        cur_tag = "wr_abort";
        Op      = 5'b00010;
        gen_instr(Op, 0, 3);
        run_q(4);
        do_reset();

        one("alu_rr",     5'b01000, 0, 0);
        one("load_w3",    5'b00001, 0, 3);
        one("beq",        5'b00100, 0, 0);
        one("bne",        5'b00101, 0, 0);
        one("jmp",        5'b00011, 1, 0);
        one("cmp",        5'b00000, 0, 0);
        one("store",      5'b00010, 2, 1);
        one("im_tmo",     5'b01000, 7, 0);
        one("illegal",    5'b10000, 0, 0);
        one("rdy_at_lim", 5'b00010, 4, 4);
        one("dm_tmo",     5'b00001, 0, 5);
        one("sh_after",   5'b01110, 0, 0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) op = OPW'($urandom_range(16, 31));
            else                           op = OPW'($urandom_range(0, 15));
            wf = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
            wd = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
            cur_tag = $sformatf("rnd%0d_op%b", i, op);
            Op = op;
            gen_instr(op, wf, wd);
            if ($urandom_range(0, 15) == 0) begin
                run_q($urandom_range(1, q.size()));
                do_reset();
            end else begin
                run_q(-1);
                if (trapped) do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
